// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
// ------------
// CPU-side OAM DMA sequencer. A CPU write to DMA_REG_ADDR latches a source
// page, halts the CPU core and takes over the shared memory bus. The block
// then copies XFER_LEN bytes from {page,8'h00} upward to OAM_DATA_ADDR, one
// READ/WRITE cycle pair per byte, and hands the bus back to the CPU.
//
// Ports:
//   cpuClk     in   CPU clock, all state moves on the rising edge
//   reset      in   asynchronous active-low reset
//   cpuAddr    in   [15:0] address from the CPU core
//   cpuDataWr  in   [7:0]  write data from the CPU core
//   cpuWrEn    in   write enable from the CPU core
//   busDataRd  in   [7:0]  read data from the memory bus (same-cycle return)
//   busAddr    out  [15:0] muxed bus address
//   busDataWr  out  [7:0]  muxed bus write data
//   busWrEn    out  muxed bus write enable
//   cpuHalt    out  CPU must stall (controller owns the bus)
//   dmaActive  out  controller owns the bus
//   dmaDone    out  one-cycle pulse during the final WRITE cycle
//
// Bus ownership: there is no valid/ready handshake on this bus. While the
// state is IDLE the CPU signals pass straight through combinationally; in any
// other state the controller drives the bus and the CPU inputs are ignored.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        cpuClk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataWr,
  input  logic        cpuWrEn,
  input  logic [7:0]  busDataRd,
  output logic [15:0] busAddr,
  output logic [7:0]  busDataWr,
  output logic        busWrEn,
  output logic        cpuHalt,
  output logic        dmaActive,
  output logic        dmaDone
);

  // The index is 8 bits wide; the transfer ends by comparing against the
  // last index, never by letting the counter wrap.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  rd_buf;
  logic        odd_cycle;

  logic        latch_page;
  logic        inc_idx;

  // State register and datapath registers.
  always_ff @(posedge cpuClk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      rd_buf    <= 8'h00;
      odd_cycle <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Parity of the current cycle, free-running from reset release.
      odd_cycle <= ~odd_cycle;
      if (latch_page) begin
        page <= cpuDataWr;
        idx  <= 8'h00;
      end else if (inc_idx) begin
        idx <= idx + 8'h01;
      end
      if (state == READ) begin
        rd_buf <= busDataRd;
      end
    end
  end

  // Next state and bus mux.
  always_comb begin
    state_nxt  = state;
    latch_page = 1'b0;
    inc_idx    = 1'b0;
    busAddr    = cpuAddr;
    busDataWr  = cpuDataWr;
    busWrEn    = cpuWrEn;
    dmaDone    = 1'b0;

    case (state)
      IDLE: begin
        // The trigger write itself is still passed to the bus.
        if (cpuWrEn && (cpuAddr == DMA_REG_ADDR)) begin
          latch_page = 1'b1;
          state_nxt  = HALT;
        end
      end

      HALT: begin
        busAddr   = {page, 8'h00};
        busDataWr = 8'h00;
        busWrEn   = 1'b0;
        // An odd HALT cycle needs one extra cycle so that reads fall on
        // the same parity as in the even case.
        state_nxt = odd_cycle ? ALIGN : READ;
      end

      ALIGN: begin
        busAddr   = {page, 8'h00};
        busDataWr = 8'h00;
        busWrEn   = 1'b0;
        state_nxt = READ;
      end

      READ: begin
        busAddr   = {page, idx};
        busDataWr = 8'h00;
        busWrEn   = 1'b0;
        state_nxt = WRITE;
      end

      WRITE: begin
        busAddr   = OAM_DATA_ADDR;
        busDataWr = rd_buf;
        busWrEn   = 1'b1;
        if (idx == LAST_IDX) begin
          dmaDone   = 1'b1;
          state_nxt = IDLE;
        end else begin
          inc_idx   = 1'b1;
          state_nxt = READ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cpuHalt   = (state != IDLE);
  assign dmaActive = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl
// ---------------
// Bench for oam_dma_ctrl. A 64 KiB byte array stands in for the memory bus
// and answers reads combinationally. A reference model computes, from the
// cycle count since reset and the cycle of the last accepted trigger, what
// every bus output must be, and a compare process checks the DUT against it
// on the falling edge of every cycle. Per-transfer statistics (halt length,
// done pulses, written bytes, addresses) are pinned to literal values.
module tb_oam_dma_ctrl;

  logic        cpuClk;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataWr;
  logic        cpuWrEn;
  logic [7:0]  busDataRd;
  logic [15:0] busAddr;
  logic [7:0]  busDataWr;
  logic        busWrEn;
  logic        cpuHalt;
  logic        dmaActive;
  logic        dmaDone;

  logic [7:0]  mem [0:65535];

  int          n_chk;
  int          n_pass;

  // Reference model state.
  int          cyc;       // cycles since reset release
  bit          have_xfer; // a trigger has been accepted since reset
  int          start;     // cycle index of the HALT cycle
  logic [7:0]  pg;

  // Observed per-transfer statistics.
  int          halt_cnt;
  int          done_cnt;
  int          wr_cnt;
  logic [7:0]  wr_q[$];
  logic [15:0] addr_q[$];

  oam_dma_ctrl dut (
    .cpuClk    (cpuClk),
    .reset     (reset),
    .cpuAddr   (cpuAddr),
    .cpuDataWr (cpuDataWr),
    .cpuWrEn   (cpuWrEn),
    .busDataRd (busDataRd),
    .busAddr   (busAddr),
    .busDataWr (busDataWr),
    .busWrEn   (busWrEn),
    .cpuHalt   (cpuHalt),
    .dmaActive (dmaActive),
    .dmaDone   (dmaDone)
  );

  assign busDataRd = mem[busAddr];

  // Clock
  initial cpuClk = 1'b0;
  always #5 cpuClk = ~cpuClk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Per-cycle compare against the model.
  always @(negedge cpuClk) begin
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic        e_we, e_halt, e_done, mask_data;
    logic [7:0]  d_got;
    int          off, al, k, i, len;
    bit          in_win;

    e_addr = cpuAddr; e_data = cpuDataWr; e_we = cpuWrEn;
    e_halt = 1'b0; e_done = 1'b0; mask_data = 1'b0;
    in_win = 1'b0;

    if (reset) begin
      al  = start & 1;
      len = 513 + al;
      in_win = have_xfer && (cyc >= start) && (cyc < start + len);
      if (in_win) begin
        off    = cyc - start;
        e_halt = 1'b1;
        if (off == 0 || (al == 1 && off == 1)) begin
          e_addr = {pg, 8'h00}; e_data = 8'h00; e_we = 1'b0;
        end else begin
          k = off - 1 - al;
          i = k / 2;
          if (k % 2 == 0) begin
            e_addr = {pg, 8'(i)}; e_we = 1'b0; mask_data = 1'b1;
          end else begin
            e_addr = 16'h2004; e_we = 1'b1;
            e_data = mem[{pg, 8'(i)}];
            e_done = (i == 255);
          end
        end
      end
    end

    d_got = mask_data ? 8'h00 : busDataWr;
    if (mask_data) e_data = 8'h00;
    chk("bus_cycle", {busAddr, d_got, busWrEn, cpuHalt, dmaActive, dmaDone},
        {e_addr, e_data, e_we, e_halt, e_halt, e_done});

    if (!reset) begin
      cyc = 0;
      have_xfer = 1'b0;
    end else begin
      if (cpuHalt) begin
        halt_cnt++;
        addr_q.push_back(busAddr);
      end
      if (dmaDone) done_cnt++;
      if (cpuHalt && busWrEn) begin
        wr_cnt++;
        wr_q.push_back(busDataWr);
      end
      if (!in_win && cpuWrEn && cpuAddr == 16'h4014) begin
        have_xfer = 1'b1;
        start     = cyc + 1;
        pg        = cpuDataWr;
      end
      cyc++;
    end
  end

  // Driver tasks
  task automatic clear_stats();
    halt_cnt = 0; done_cnt = 0; wr_cnt = 0;
    wr_q.delete(); addr_q.delete();
  endtask

  task automatic junk(input bit allow_trig);
    cpuAddr   = 16'($urandom);
    cpuDataWr = 8'($urandom);
    cpuWrEn   = 1'($urandom_range(0, 1));
    if (cpuAddr == 16'h4014) cpuAddr = 16'h4015;
    // While halted, aim some writes at the trigger register on purpose.
    if (allow_trig && $urandom_range(0, 7) == 0) begin
      cpuAddr = 16'h4014; cpuWrEn = 1'b1;
    end
  endtask

  task automatic trigger_on_parity(input logic [7:0] p, input int odd_halt);
    bit fired;
    fired = 1'b0;
    for (int g = 0; g < 4 && !fired; g++) begin
      @(posedge cpuClk); #1;
      if (((cyc + 1) & 1) == odd_halt) begin
        cpuAddr = 16'h4014; cpuWrEn = 1'b1; cpuDataWr = p;
        fired = 1'b1;
      end else begin
        junk(1'b0);
      end
    end
    chk("trigger_issued", 32'(fired), 32'd1);
  endtask

  task automatic run_xfer(input logic [7:0] p, input int odd_halt);
    clear_stats();
    trigger_on_parity(p, odd_halt);
    for (int c = 0; c < 530; c++) begin
      @(posedge cpuClk); #1;
      junk(c < 400);
    end
  endtask

  task automatic check_page2(input string tag, input int exp_len);
    int bad;
    chk({tag, "_halt_len"}, 32'(halt_cnt), 32'(exp_len));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_wr_cnt"},   32'(wr_q.size()), 32'd256);
    if (wr_q.size() == 256) begin
      chk({tag, "_first"}, 32'(wr_q[0]),   32'h5A);
      chk({tag, "_last"},  32'(wr_q[255]), 32'hA5);
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wr_q[i] !== (8'(i) ^ 8'h5A)) bad++;
      chk({tag, "_seq_errs"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int sz;
    bit hit;
    n_chk = 0; n_pass = 0;
    cyc = 0; have_xfer = 1'b0; start = 0; pg = 8'h00;
    clear_stats();
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    // Reset with random inputs: outputs must pass through.
    reset = 1'b0;
    junk(1'b0);
    #1;
    chk("reset_halt", {31'd0, cpuHalt}, 32'd0);
    chk("reset_addr", {16'd0, busAddr}, {16'd0, cpuAddr});
    for (int c = 0; c < 4; c++) begin
      @(posedge cpuClk); #1;
      junk(1'b0);
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge cpuClk); #1;
      junk(1'b0);
    end

    // Non-trigger writes to neighbouring registers.
    clear_stats();
    @(posedge cpuClk); #1;
    cpuAddr = 16'h4013; cpuDataWr = 8'h07; cpuWrEn = 1'b1;
    @(posedge cpuClk); #1;
    cpuAddr = 16'h4015; cpuDataWr = 8'h07; cpuWrEn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge cpuClk); #1;
      junk(1'b0);
    end
    chk("nontrig_halt", 32'(halt_cnt), 32'd0);

    // Even and odd start transfers from page 2.
    run_xfer(8'h02, 0);
    check_page2("even", 513);
    run_xfer(8'h02, 1);
    check_page2("odd", 514);

    // Address sweep on page FF.
    run_xfer(8'hFF, 0);
    chk("ff_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("ff_done", 32'(done_cnt), 32'd1);
    sz = addr_q.size();
    if (sz >= 3) begin
      chk("ff_first", {16'd0, addr_q[0]}, 32'h0000FF00);
      chk("ff_lastrd", {16'd0, addr_q[sz-2]}, 32'h0000FFFF);
      chk("ff_lastwr", {16'd0, addr_q[sz-1]}, 32'h00002004);
    end else begin
      chk("ff_addr_q", 32'(sz), 32'd513);
    end

    // Reset in the middle of a transfer.
    clear_stats();
    trigger_on_parity(8'h02, 0);
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(posedge cpuClk); #1;
      if (wr_cnt >= 100) hit = 1'b1;
      else junk(1'b1);
    end
    chk("midrst_reached", 32'(hit), 32'd1);
    reset = 1'b0;
    junk(1'b0);
    #1;
    chk("midrst_halt", {31'd0, cpuHalt}, 32'd0);
    chk("midrst_addr", {16'd0, busAddr}, {16'd0, cpuAddr});
    @(posedge cpuClk); #1;
    reset = 1'b1;
    junk(1'b0);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge cpuClk); #1;
      junk(1'b0);
    end
    run_xfer(8'h02, 1);
    check_page2("after_rst", 514);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sequences the CPU-side OAM DMA triggered by a write to $4014. Halts the RP2A03 core and takes ownership of the shared CPU memory bus (addr/dataWr/wrEn into the RAM/memory-select fabric). Copies 256 bytes from page {value,8'h00} to the OAM data port $2004, then returns the bus to the CPU. Sits between the cpu instance and the memory bus in nes, clocked by cpuClk.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA
OAM_DATA_ADDR, 16'h2004, destination address for each DMA write
XFER_LEN, 256, bytes per transfer (8-bit index; must be 256)

Ports:
cpuClk  input  1  CPU clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
cpuAddr  input  16  address driven by CPU core
cpuDataWr  input  8  write data driven by CPU core
cpuWrEn  input  1  write enable driven by CPU core
busDataRd  input  8  read data returned from memory bus
busAddr  output  16  muxed address to memory bus
busDataWr  output  8  muxed write data to memory bus
busWrEn  output  1  muxed write enable to memory bus
cpuHalt  output  1  high while the CPU must stall (owns no bus)
dmaActive  output  1  high while the controller owns the bus
dmaDone  output  1  one-cycle pulse on the final write cycle

Behaviour:
- Reset (reset=0, async): state=IDLE, page=0, idx=0, rdBuf=0, oddCycle=0; cpuHalt=0, dmaActive=0, dmaDone=0; bus outputs follow the CPU inputs.
- oddCycle toggles every cpuClk edge after reset; it is the parity of the current cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: bus = CPU inputs (combinational pass-through). If cpuWrEn=1 and cpuAddr=DMA_REG_ADDR: latch page<=cpuDataWr, idx<=0, next=HALT. The trigger write itself still reaches the bus.
- HALT (1 cycle): cpuHalt=1, dmaActive=1, busWrEn=0, busAddr={page,8'h00}, busDataWr=0. Next=ALIGN if oddCycle=1 during HALT, else READ.
- ALIGN (1 cycle): same bus outputs as HALT; next=READ.
- READ: busAddr={page,idx}, busWrEn=0; rdBuf<=busDataRd at the closing edge; next=WRITE.
- WRITE: busAddr=OAM_DATA_ADDR, busDataWr=rdBuf, busWrEn=1. If idx=8'hFF: dmaDone=1, next=IDLE. Otherwise idx<=idx+1, next=READ.
- cpuHalt and dmaActive are decoded from state (state!=IDLE). Both deassert in the first IDLE cycle after the final WRITE.
- Halted length: 513 cycles (HALT, then 256×READ/WRITE) if HALT falls on an even cycle; 514 cycles if odd.
- idx is 8 bits. The increment after 8'hFF is never taken; termination is by compare, not by wrap.
- Addresses: {page,idx} with page=8'hFF reaches 16'hFFFF. There is no special handling.
- CPU writes to DMA_REG_ADDR while not in IDLE are ignored. The CPU is halted then, but the inputs are still not decoded.
- busDataRd is sampled only in READ. Memory returns data within the same cpuClk cycle.
- An async reset mid-transfer aborts immediately: bus returns to the CPU, cpuHalt=0, and no dmaDone pulse is issued.

Test Plan:
- Reset check: assert reset=0 with any inputs -> cpuHalt=0, dmaActive=0, dmaDone=0, busAddr=cpuAddr, busWrEn=cpuWrEn.
- Even-start transfer: preload page $02 with byte[i]=i^8'h5A; write 8'h02 to $4014 so HALT lands on an even cycle -> cpuHalt high 513 cycles; 256 writes to $2004 with data 8'h5A, 8'h5B, ..., 8'hA5 in order; dmaDone pulses once on the last write.
- Odd-start transfer: same stimulus, trigger shifted one cycle so HALT is odd -> one ALIGN cycle; cpuHalt high 514 cycles; same data sequence.
- Address sweep: page 8'hFF -> READ addresses 16'hFF00..16'hFFFF in ascending order, interleaved strictly READ/WRITE, busWrEn=1 only on WRITE.
- Non-trigger writes: CPU writes 8'h07 to $4013 and $4015 -> no state change; bus passes through unchanged.
- Mid-transfer reset: pulse reset low after 100 WRITE cycles -> outputs immediately return to the CPU pass-through with cpuHalt=0 and no dmaDone. A new $4014 write then starts a fresh transfer from idx=0.
